// File: rtl/battleship_pkg.sv
// Shared battleship definitions: board geometry, cell encodings, resolver state
// and result kinds. Used by the placement stage, the shot resolver and the renderer.
package battleship_pkg;

  localparam int unsigned N       = 5;
  localparam int unsigned CELL_W  = 3;
  localparam int unsigned COORD_W = 3;

  typedef logic [CELL_W-1:0] cell_t;
  typedef cell_t [N-1:0][N-1:0] board_t;

  localparam cell_t CELL_WATER  = 3'd0;
  localparam cell_t CELL_MISS   = 3'd6;
  localparam cell_t CELL_HIT    = 3'd7;
  localparam cell_t SHIP_ID_MAX = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    REPORT  = 2'd2
  } res_state_e;

  typedef enum logic [1:0] {
    RES_MISS    = 2'd0,
    RES_HIT     = 2'd1,
    RES_REPEAT  = 2'd2,
    RES_INVALID = 2'd3
  } res_kind_e;

  // True for an unshot ship cell (ids 1..SHIP_ID_MAX).
  function automatic logic is_ship(input cell_t c);
    return (c >= 3'd1) && (c <= SHIP_ID_MAX);
  endfunction

endpackage

// File: rtl/board_scan.sv
// Combinational board scan.
// Ports:
//   board            in  board to scan
//   id               in  cell value to search for
//   id_present       out some cell equals id
//   any_ship_present out some cell still holds an unshot ship id
module board_scan
  import battleship_pkg::*;
(
  input  logic [N-1:0][N-1:0][CELL_W-1:0] board,
  input  logic [CELL_W-1:0]               id,
  output logic                            id_present,
  output logic                            any_ship_present
);

  always_comb begin
    id_present       = 1'b0;
    any_ship_present = 1'b0;
    for (int unsigned r = 0; r < N; r++) begin
      for (int unsigned c = 0; c < N; c++) begin
        if (board[r][c] == id) id_present = 1'b1;
        if (is_ship(board[r][c])) any_ship_present = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shot_resolver.sv
// Opponent-side shot engine: holds a private copy of the placed board, resolves
// one shot per fire edge and marks hits (7) / misses (6) in the board.
// Optional feature macro: SHOT_RESOLVER_SHOT_LIMIT_EN (shot budget of MAX_SHOTS,
// adds the shots_left output).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load, board_in  copy a placed board in and clear all status
//   enable          shots accepted only while high
//   x, y, fire      target column/row and shot request (rising edge of fire)
//   board_out       internal board including marks
//   done            one-cycle pulse, result flags valid
//   hit/miss/repeat_shot/invalid, sunk, sunk_id   per-shot result
//   all_sunk, game_over                           sticky game status
//   shots_left      remaining budget (limit build only)
module shot_resolver
  import battleship_pkg::*;
`ifdef SHOT_RESOLVER_SHOT_LIMIT_EN
#(
  parameter  int unsigned MAX_SHOTS = 15,
  localparam int unsigned SHOT_W    = $clog2(MAX_SHOTS + 1)
)
`endif
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load,
  input  logic [N-1:0][N-1:0][CELL_W-1:0] board_in,
  input  logic                            enable,
  input  logic [COORD_W-1:0]              x,
  input  logic [COORD_W-1:0]              y,
  input  logic                            fire,
  output logic [N-1:0][N-1:0][CELL_W-1:0] board_out,
  output logic                            done,
  output logic                            hit,
  output logic                            miss,
  output logic                            repeat_shot,
  output logic                            invalid,
  output logic                            sunk,
  output logic [CELL_W-1:0]               sunk_id,
  output logic                            all_sunk,
  output logic                            game_over
`ifdef SHOT_RESOLVER_SHOT_LIMIT_EN
  ,
  output logic [SHOT_W-1:0]               shots_left
`endif
);

  res_state_e          state_q, state_d;
  res_kind_e           kind_q, kind_d;
  board_t              board_q, board_d;
  logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
  cell_t               hit_id_q, hit_id_d;
  logic                fire_q;
  logic                done_q, done_d, hit_q, hit_d, miss_q, miss_d;
  logic                rep_q, rep_d, inv_q, inv_d, sunk_q, sunk_d;
  cell_t               sunk_id_q, sunk_id_d;
  logic                all_sunk_q, all_sunk_d, game_over_q, game_over_d;
`ifdef SHOT_RESOLVER_SHOT_LIMIT_EN
  logic [SHOT_W-1:0]   shots_used_q, shots_used_d, shots_left_q, shots_left_d;
  logic                limit_reached;
`endif

  logic  request;
  logic  coord_ok;
  cell_t cell_sel;
  logic  write_en;
  cell_t write_val;
  logic  id_present, any_ship_present;

  // Scans the current (already marked) board during REPORT.
  board_scan u_scan (
    .board            (board_q),
    .id               (hit_id_q),
    .id_present       (id_present),
    .any_ship_present (any_ship_present)
  );

  assign request  = fire & ~fire_q & enable & ~game_over_q;
  assign coord_ok = (x_q < COORD_W'(N)) && (y_q < COORD_W'(N));

  // Target cell lookup; loop form keeps out-of-range coordinates from indexing.
  always_comb begin
    cell_sel = CELL_WATER;
    for (int unsigned r = 0; r < N; r++) begin
      for (int unsigned c = 0; c < N; c++) begin
        if (COORD_W'(r) == y_q && COORD_W'(c) == x_q) cell_sel = board_q[r][c];
      end
    end
  end

  // Next state, board update and result flags.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    board_d     = board_q;
    x_d         = x_q;
    y_d         = y_q;
    hit_id_d    = hit_id_q;
    done_d      = 1'b0;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    rep_d       = 1'b0;
    inv_d       = 1'b0;
    sunk_d      = 1'b0;
    sunk_id_d   = CELL_WATER;
    all_sunk_d  = all_sunk_q;
    game_over_d = game_over_q;
    write_en    = 1'b0;
    write_val   = CELL_WATER;
`ifdef SHOT_RESOLVER_SHOT_LIMIT_EN
    shots_used_d  = shots_used_q;
    shots_left_d  = shots_left_q;
    limit_reached = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (request) begin
          x_d     = x;
          y_d     = y;
          state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        state_d = REPORT;
        if (!coord_ok) begin
          kind_d = RES_INVALID;
        end else if (cell_sel == CELL_MISS || cell_sel == CELL_HIT) begin
          kind_d = RES_REPEAT;
        end else if (is_ship(cell_sel)) begin
          kind_d    = RES_HIT;
          hit_id_d  = cell_sel;
          write_en  = 1'b1;
          write_val = CELL_HIT;
        end else begin
          kind_d    = RES_MISS;
          write_en  = 1'b1;
          write_val = CELL_MISS;
        end
      end
      REPORT: begin
        state_d    = IDLE;
        done_d     = 1'b1;
        hit_d      = (kind_q == RES_HIT);
        miss_d     = (kind_q == RES_MISS);
        rep_d      = (kind_q == RES_REPEAT);
        inv_d      = (kind_q == RES_INVALID);
        // Board already carries this shot's mark, so a missing id means sunk.
        sunk_d     = (kind_q == RES_HIT) && !id_present;
        sunk_id_d  = sunk_d ? hit_id_q : CELL_WATER;
        all_sunk_d = all_sunk_q | ~any_ship_present;
`ifdef SHOT_RESOLVER_SHOT_LIMIT_EN
        if (kind_q == RES_HIT || kind_q == RES_MISS) shots_used_d = shots_used_q + SHOT_W'(1);
        limit_reached = (shots_used_d == SHOT_W'(MAX_SHOTS)) && any_ship_present;
        shots_left_d  = SHOT_W'(MAX_SHOTS) - shots_used_d;
        game_over_d   = game_over_q | all_sunk_d | limit_reached;
`else
        game_over_d   = game_over_q | all_sunk_d;
`endif
      end
      default: state_d = IDLE;
    endcase

    if (write_en) begin
      for (int unsigned r = 0; r < N; r++) begin
        for (int unsigned c = 0; c < N; c++) begin
          if (COORD_W'(r) == y_q && COORD_W'(c) == x_q) board_d[r][c] = write_val;
        end
      end
    end

    // Load overrides everything but reset and drops any shot in flight.
    if (load) begin
      state_d     = IDLE;
      board_d     = board_in;
      done_d      = 1'b0;
      hit_d       = 1'b0;
      miss_d      = 1'b0;
      rep_d       = 1'b0;
      inv_d       = 1'b0;
      sunk_d      = 1'b0;
      sunk_id_d   = CELL_WATER;
      all_sunk_d  = 1'b0;
      game_over_d = 1'b0;
`ifdef SHOT_RESOLVER_SHOT_LIMIT_EN
      shots_used_d = '0;
      shots_left_d = SHOT_W'(MAX_SHOTS);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      kind_q      <= RES_MISS;
      board_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      hit_id_q    <= CELL_WATER;
      fire_q      <= 1'b0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      rep_q       <= 1'b0;
      inv_q       <= 1'b0;
      sunk_q      <= 1'b0;
      sunk_id_q   <= CELL_WATER;
      all_sunk_q  <= 1'b0;
      game_over_q <= 1'b0;
`ifdef SHOT_RESOLVER_SHOT_LIMIT_EN
      shots_used_q <= '0;
      shots_left_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      board_q     <= board_d;
      x_q         <= x_d;
      y_q         <= y_d;
      hit_id_q    <= hit_id_d;
      fire_q      <= fire;
      done_q      <= done_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      rep_q       <= rep_d;
      inv_q       <= inv_d;
      sunk_q      <= sunk_d;
      sunk_id_q   <= sunk_id_d;
      all_sunk_q  <= all_sunk_d;
      game_over_q <= game_over_d;
`ifdef SHOT_RESOLVER_SHOT_LIMIT_EN
      shots_used_q <= shots_used_d;
      shots_left_q <= shots_left_d;
`endif
    end
  end

  assign board_out   = board_q;
  assign done        = done_q;
  assign hit         = hit_q;
  assign miss        = miss_q;
  assign repeat_shot = rep_q;
  assign invalid     = inv_q;
  assign sunk        = sunk_q;
  assign sunk_id     = sunk_id_q;
  assign all_sunk    = all_sunk_q;
  assign game_over   = game_over_q;
`ifdef SHOT_RESOLVER_SHOT_LIMIT_EN
  assign shots_left  = shots_left_q;
`endif

endmodule
